// File: rtl/odd_parity_sched.sv
// Two-requester round-robin scheduler feeding an LSB-first serial engine that
// reports the odd-parity bit of each granted word.
module odd_parity_sched #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ser_bit,
  output logic          ser_en,
  output logic          busy,
  output logic          done,
  output logic          parity
);

  localparam int unsigned CW = $clog2(DW) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          ser_bit_q, ser_bit_d;
  logic          ser_en_q, ser_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          parity_q, parity_d;
  logic          grant_sel;

  // Outputs are computed one cycle ahead so every output is a plain flop.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    last_d    = last_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    busy_d    = busy_q;
    parity_d  = parity_q;
    ser_bit_d = 1'b0;
    ser_en_d  = 1'b0;
    done_d    = 1'b0;
    grant_sel = 1'b0;

    case (state_q)
      StIdle: begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        busy_d = 1'b0;
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          grant_sel = (req0 && req1) ? ~last_q : req1;
          state_d   = StShift;
          shreg_d   = grant_sel ? data1 : data0;
          cnt_d     = '0;
          acc_d     = 1'b0;
          last_d    = grant_sel;
          gnt0_d    = ~grant_sel;
          gnt1_d    = grant_sel;
          busy_d    = 1'b1;
          ser_en_d  = 1'b1;
          ser_bit_d = grant_sel ? data1[0] : data0[0];
        end
      end
      StShift: begin
        busy_d  = 1'b1;
        acc_d   = acc_q ^ shreg_q[0];
        shreg_d = {1'b0, shreg_q[DW-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d  = StDone;
          done_d   = 1'b1;
          parity_d = ~(acc_q ^ shreg_q[0]);
        end else begin
          ser_en_d  = 1'b1;
          ser_bit_d = shreg_q[1];
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ser_bit_q <= 1'b0;
      ser_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      ser_bit_q <= ser_bit_d;
      ser_en_q  <= ser_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      parity_q  <= parity_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign ser_bit = ser_bit_q;
  assign ser_en  = ser_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign parity  = parity_q;

endmodule

// File: tb/tb_odd_parity_sched.sv
// Directed and random checks for odd_parity_sched at DW=8: serial order,
// parity, round-robin grants, latency and reset behaviour.
module tb_odd_parity_sched;

  logic       clk;
  logic       arstn;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, ser_bit, ser_en, busy, done, parity;

  int   n_tests;
  int   n_fail;
  logic m_last;

  odd_parity_sched #(.DW(8)) dut (
    .clk     (clk),
    .arstn   (arstn),
    .req0    (req0),
    .data0   (data0),
    .req1    (req1),
    .data1   (data1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .ser_bit (ser_bit),
    .ser_en  (ser_en),
    .busy    (busy),
    .done    (done),
    .parity  (parity)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt0"},    gnt0,    0);
    check_eq({tag, "_gnt1"},    gnt1,    0);
    check_eq({tag, "_ser_bit"}, ser_bit, 0);
    check_eq({tag, "_ser_en"},  ser_en,  0);
    check_eq({tag, "_busy"},    busy,    0);
    check_eq({tag, "_done"},    done,    0);
    check_eq({tag, "_parity"},  parity,  0);
  endtask

  // Reset with both requests asserted; they must be ignored.
  task automatic do_reset(input int cycles);
    arstn = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      check_all_zero("reset");
    end
    m_last = 1'b1;
    arstn  = 1'b1;
  endtask

  // One full transaction: acceptance edge, 8 shift cycles, DONE, then IDLE.
  task automatic txn(input logic r0, input logic r1, input logic [7:0] d0,
                     input logic [7:0] d1, input bit hold, input logic exp_par);
    logic       g;
    logic [7:0] w;
    g      = (r0 && r1) ? ~m_last : r1;
    m_last = g;
    w      = g ? d1 : d0;
    req0   = r0;
    req1   = r1;
    data0  = d0;
    data1  = d1;
    step();
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    data0 = ~d0;
    data1 = ~d1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("shift%0d_ser_en", k),  ser_en,  1);
      check_eq($sformatf("shift%0d_ser_bit", k), ser_bit, w[k]);
      check_eq($sformatf("shift%0d_gnt0", k),    gnt0,    !g);
      check_eq($sformatf("shift%0d_gnt1", k),    gnt1,    g);
      check_eq($sformatf("shift%0d_busy", k),    busy,    1);
      check_eq($sformatf("shift%0d_done", k),    done,    0);
      step();
    end
    check_eq("done_pulse",  done,   1);
    check_eq("done_parity", parity, exp_par);
    check_eq("done_ser_en", ser_en, 0);
    check_eq("done_gnt0",   gnt0,   !g);
    check_eq("done_gnt1",   gnt1,   g);
    check_eq("done_busy",   busy,   1);
    step();
    check_eq("idle_done",   done,   0);
    check_eq("idle_parity", parity, exp_par);
    check_eq("idle_gnt0",   gnt0,   0);
    check_eq("idle_gnt1",   gnt1,   0);
    check_eq("idle_busy",   busy,   0);
    check_eq("idle_ser_en", ser_en, 0);
  endtask

  initial begin
    logic       seen_done;
    logic       seen_busy;
    logic [1:0] r;
    logic [7:0] rd0, rd1;
    logic       gp;

    n_tests = 0;
    n_fail  = 0;
    m_last  = 1'b1;
    clk     = 1'b0;
    arstn   = 1'b0;
    req0    = 1'b0;
    req1    = 1'b0;
    data0   = 8'h03;
    data1   = 8'h01;

    do_reset(3);

    // Contention: both held, grants alternate starting with requester 0.
    txn(1'b1, 1'b1, 8'h03, 8'h01, 1'b1, 1'b1);
    txn(1'b1, 1'b1, 8'h03, 8'h01, 1'b1, 1'b0);
    txn(1'b1, 1'b1, 8'h03, 8'h01, 1'b1, 1'b1);
    txn(1'b1, 1'b1, 8'h03, 8'h01, 1'b0, 1'b0);

    // Single request, bits 1,1,1,0,0,0,0,0.
    txn(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0);

    // Parity corners.
    txn(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    txn(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1);
    txn(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    txn(1'b0, 1'b1, 8'h00, 8'h80, 1'b0, 1'b0);

    // One-cycle request pulse still completes.
    txn(1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b1);

    // Reset during the 4th shift cycle aborts without a done pulse.
    req1  = 1'b1;
    data1 = 8'hA5;
    step();
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("abort_pre_busy", busy, 1);
    arstn = 1'b0;
    step();
    check_all_zero("abort");
    arstn     = 1'b1;
    m_last    = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_done = seen_done | done;
      seen_busy = seen_busy | busy;
    end
    check_eq("abort_no_done", seen_done, 0);
    check_eq("abort_no_busy", seen_busy, 0);
    txn(1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1);

    // Random words on random requesters.
    for (int n = 0; n < 50; n++) begin
      r   = 2'($urandom_range(1, 3));
      rd0 = 8'($urandom);
      rd1 = 8'($urandom);
      gp  = (r[0] && r[1]) ? ~m_last : r[1];
      txn(r[0], r[1], rd0, rd1, 1'b0, ~^(gp ? rd1 : rd0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
